// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file write port. ALU results take priority; load results wait in a small FIFO.
// Define WB_ARB_BYPASS_EN to drive the rs1/rs2 forwarding outputs; otherwise those outputs are tied to 0.
module regfile_wb_arbiter #(
    parameter int n       = 32,
    parameter int address = 5,
    parameter int depth   = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         alu_wr_i,
    input  logic [address-1:0]           alu_addr_i,
    input  logic [n-1:0]                 alu_data_i,
    output logic                         alu_stall_o,
    input  logic                         lsu_valid_i,
    output logic                         lsu_ready_o,
    input  logic [address-1:0]           lsu_addr_i,
    input  logic [n-1:0]                 lsu_data_i,
    output logic                         rd_wr_o,
    output logic [address-1:0]           rd_addr_o,
    output logic [n-1:0]                 rd_data_o,
    output logic [$clog2(depth+1)-1:0]   count_o,
    input  logic [address-1:0]           rs1_addr_i,
    input  logic [address-1:0]           rs2_addr_i,
    output logic                         rs1_fwd_o,
    output logic                         rs2_fwd_o,
    output logic [n-1:0]                 rs1_fwd_data_o,
    output logic [n-1:0]                 rs2_fwd_data_o
);

    localparam int PW = $clog2(depth);
    localparam int CW = $clog2(depth+1);

    logic [address-1:0] fifo_addr_mem [depth];
    logic [n-1:0]       fifo_data_mem [depth];

    logic [PW-1:0] head_reg, tail_reg;
    logic [CW-1:0] count_reg;
    logic [depth-1:0] hit_vec;

    logic fifo_full, fifo_empty, alu_take, pop, push;

    // An ALU write must not overtake a queued load to the same register.
    generate
        for (genvar gi = 0; gi < depth; gi++) begin : g_hit
            logic [PW-1:0] offset;
            assign offset      = PW'(gi) - head_reg;
            assign hit_vec[gi] = (CW'(offset) < count_reg) && (fifo_addr_mem[gi] == alu_addr_i);
        end
    endgenerate

    assign fifo_full   = (count_reg == CW'(depth));
    assign fifo_empty  = (count_reg == '0);
    assign lsu_ready_o = !rst_i && !fifo_full;
    assign alu_stall_o = alu_wr_i && (fifo_full || (|hit_vec));
    assign alu_take    = alu_wr_i && !alu_stall_o && (alu_addr_i != '0);
    assign pop         = !alu_take && !fifo_empty;
    // Loads to x0 are handshaken but never stored.
    assign push        = lsu_valid_i && lsu_ready_o && (lsu_addr_i != '0);
    assign count_o     = count_reg;

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_addr_mem[tail_reg] <= lsu_addr_i;
            fifo_data_mem[tail_reg] <= lsu_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            rd_wr_o   <= 1'b0;
            rd_addr_o <= '0;
            rd_data_o <= '0;
        end else begin
            if (push) tail_reg <= tail_reg + 1'b1;
            if (pop)  head_reg <= head_reg + 1'b1;
            if (push && !pop)
                count_reg <= count_reg + 1'b1;
            else if (pop && !push)
                count_reg <= count_reg - 1'b1;

            if (alu_take) begin
                rd_wr_o   <= 1'b1;
                rd_addr_o <= alu_addr_i;
                rd_data_o <= alu_data_i;
            end else if (pop) begin
                rd_wr_o   <= 1'b1;
                rd_addr_o <= fifo_addr_mem[head_reg];
                rd_data_o <= fifo_data_mem[head_reg];
            end else begin
                rd_wr_o   <= 1'b0;
            end
        end
    end

`ifdef WB_ARB_BYPASS_EN
    // Covers the cycle where the register file still returns the pre-write value.
    always_comb begin
        rs1_fwd_o      = rd_wr_o && (rd_addr_o == rs1_addr_i) && (rs1_addr_i != '0);
        rs2_fwd_o      = rd_wr_o && (rd_addr_o == rs2_addr_i) && (rs2_addr_i != '0);
        rs1_fwd_data_o = rs1_fwd_o ? rd_data_o : '0;
        rs2_fwd_data_o = rs2_fwd_o ? rd_data_o : '0;
    end
`else
    logic unused_rs;
    assign unused_rs      = ^{rs1_addr_i, rs2_addr_i};
    assign rs1_fwd_o      = 1'b0;
    assign rs2_fwd_o      = 1'b0;
    assign rs1_fwd_data_o = '0;
    assign rs2_fwd_data_o = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a queue-based reference model.
// Forwarding expectations follow WB_ARB_BYPASS_EN.
module tb_regfile_wb_arbiter;

    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        alu_wr_i = 1'b0;
    logic [4:0]  alu_addr_i = '0;
    logic [31:0] alu_data_i = '0;
    logic        alu_stall_o;
    logic        lsu_valid_i = 1'b0;
    logic        lsu_ready_o;
    logic [4:0]  lsu_addr_i = '0;
    logic [31:0] lsu_data_i = '0;
    logic        rd_wr_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic [2:0]  count_o;
    logic [4:0]  rs1_addr_i = '0;
    logic [4:0]  rs2_addr_i = '0;
    logic        rs1_fwd_o, rs2_fwd_o;
    logic [31:0] rs1_fwd_data_o, rs2_fwd_data_o;

    regfile_wb_arbiter #(.n(32), .address(5), .depth(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .alu_wr_i(alu_wr_i), .alu_addr_i(alu_addr_i), .alu_data_i(alu_data_i), .alu_stall_o(alu_stall_o),
        .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o), .lsu_addr_i(lsu_addr_i), .lsu_data_i(lsu_data_i),
        .rd_wr_o(rd_wr_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o), .count_o(count_o),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .rs1_fwd_o(rs1_fwd_o), .rs2_fwd_o(rs2_fwd_o),
        .rs1_fwd_data_o(rs1_fwd_data_o), .rs2_fwd_data_o(rs2_fwd_data_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed { logic [4:0] a; logic [31:0] d; } wb_t;
    wb_t q[$];

    int checks = 0;
    int failures = 0;

    // model state: what is currently on rd_* and what should appear after the next edge
    logic        cur_wr = 1'b0;
    logic [4:0]  cur_addr = '0;
    logic [31:0] cur_data = '0;
    logic        nxt_wr;
    logic [4:0]  nxt_addr;
    logic [31:0] nxt_data;
    logic        exp_stall, exp_ready;
    int          exp_count;
    logic        exp_f1, exp_f2;
    logic [31:0] exp_fd1, exp_fd2;

    function automatic logic fwd_hit(input logic [4:0] rs);
`ifdef WB_ARB_BYPASS_EN
        return cur_wr && (cur_addr == rs) && (rs != 0);
`else
        return 1'b0;
`endif
    endfunction

    // Drive one cycle of inputs and advance the reference model (no comparisons here).
    task automatic model_step(input logic aw, input logic [4:0] aa, input logic [31:0] ad,
                              input logic lv, input logic [4:0] la, input logic [31:0] ld);
        bit hit, take, pop;
        alu_wr_i = aw; alu_addr_i = aa; alu_data_i = ad;
        lsu_valid_i = lv; lsu_addr_i = la; lsu_data_i = ld;
        #1;
        hit = 0;
        foreach (q[i]) if (q[i].a == aa) hit = 1;
        exp_count = q.size();
        exp_ready = (q.size() < DEPTH);
        exp_stall = aw && ((q.size() == DEPTH) || hit);
        take = aw && !exp_stall && (aa != 0);
        pop = !take && (q.size() > 0);
        exp_f1 = fwd_hit(rs1_addr_i); exp_fd1 = exp_f1 ? cur_data : 32'h0;
        exp_f2 = fwd_hit(rs2_addr_i); exp_fd2 = exp_f2 ? cur_data : 32'h0;
        nxt_wr = take || pop; nxt_addr = cur_addr; nxt_data = cur_data;
        if (take) begin nxt_addr = aa; nxt_data = ad; end
        else if (pop) begin nxt_addr = q[0].a; nxt_data = q[0].d; end
        if (pop) void'(q.pop_front());
        if (lv && exp_ready && la != 0) q.push_back('{a: la, d: ld});
    endtask

    task automatic tick();
        @(posedge clk_i); #1;
        cur_wr = nxt_wr; cur_addr = nxt_addr; cur_data = nxt_data;
    endtask

    task automatic test_reset();
        alu_wr_i = 1'b1; alu_addr_i = 5'd3;
        #1;
        checks++; if (rd_wr_o !== 1'b0) begin failures++; $display("FAIL reset_rd_wr: got %0b expected 0", rd_wr_o); end
        checks++; if (rd_addr_o !== 5'd0 || rd_data_o !== 32'd0) begin failures++; $display("FAIL reset_rd_addr_data: got %0h/%0h expected 0/0", rd_addr_o, rd_data_o); end
        checks++; if (count_o !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", count_o); end
        checks++; if (lsu_ready_o !== 1'b0) begin failures++; $display("FAIL reset_ready: got %0b expected 0", lsu_ready_o); end
        checks++; if (alu_stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall: got %0b expected 0", alu_stall_o); end
        checks++; if ({rs1_fwd_o, rs2_fwd_o} !== 2'b00) begin failures++; $display("FAIL reset_fwd: got %b expected 00", {rs1_fwd_o, rs2_fwd_o}); end
        @(posedge clk_i); #1;
        alu_wr_i = 1'b0; alu_addr_i = '0;
        #2 rst_i = 1'b0;
        #1;
        checks++; if (lsu_ready_o !== 1'b1) begin failures++; $display("FAIL release_ready: got %0b expected 1", lsu_ready_o); end
        @(posedge clk_i); #1;
    endtask

    task automatic test_alu_single();
        model_step(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'h0);
        checks++; if (alu_stall_o !== 1'b0) begin failures++; $display("FAIL alu_single_stall: got %0b expected 0", alu_stall_o); end
        tick();
        checks++; if ({rd_wr_o, rd_addr_o, rd_data_o} !== {1'b1, 5'd5, 32'h11})
            begin failures++; $display("FAIL alu_single_rd: got wr=%0b a=%0d d=%0h expected wr=1 a=5 d=11", rd_wr_o, rd_addr_o, rd_data_o); end
    endtask

    task automatic test_fill_and_drain();
        for (int i = 1; i <= 4; i++) begin
            model_step(1'b1, 5'(16 + i), $urandom, 1'b1, 5'(i), 32'h100 + i);
            tick();
        end
        model_step(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h105);
        checks++; if (count_o !== 3'd4) begin failures++; $display("FAIL fill_count: got %0d expected 4", count_o); end
        checks++; if (lsu_ready_o !== 1'b0) begin failures++; $display("FAIL fill_ready_full: got %0b expected 0", lsu_ready_o); end
        tick();
        for (int i = 1; i <= 4; i++) begin
            checks++; if ({rd_wr_o, rd_addr_o, rd_data_o} !== {1'b1, 5'(i), 32'h100 + i})
                begin failures++; $display("FAIL drain_order_%0d: got wr=%0b a=%0d d=%0h expected wr=1 a=%0d d=%0h", i, rd_wr_o, rd_addr_o, rd_data_o, i, 32'h100 + i); end
            model_step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
            tick();
        end
        checks++; if (rd_wr_o !== 1'b0 || count_o !== 3'd0) begin failures++; $display("FAIL drain_empty: got wr=%0b count=%0d expected 0/0", rd_wr_o, count_o); end
    endtask

    task automatic test_waw();
        model_step(1'b1, 5'd21, 32'h2121, 1'b1, 5'd7, 32'h77);
        tick();
        model_step(1'b1, 5'd7, 32'hAA, 1'b0, 5'd0, 32'h0);
        checks++; if (alu_stall_o !== 1'b1) begin failures++; $display("FAIL waw_stall: got %0b expected 1", alu_stall_o); end
        tick();
        checks++; if ({rd_wr_o, rd_addr_o, rd_data_o} !== {1'b1, 5'd7, 32'h77})
            begin failures++; $display("FAIL waw_load_first: got wr=%0b a=%0d d=%0h expected wr=1 a=7 d=77", rd_wr_o, rd_addr_o, rd_data_o); end
        model_step(1'b1, 5'd7, 32'hAA, 1'b0, 5'd0, 32'h0);
        checks++; if (alu_stall_o !== 1'b0) begin failures++; $display("FAIL waw_release: got %0b expected 0", alu_stall_o); end
        tick();
        checks++; if ({rd_wr_o, rd_addr_o, rd_data_o} !== {1'b1, 5'd7, 32'hAA})
            begin failures++; $display("FAIL waw_alu_second: got wr=%0b a=%0d d=%0h expected wr=1 a=7 d=aa", rd_wr_o, rd_addr_o, rd_data_o); end
        model_step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
    endtask

    task automatic test_x0();
        model_step(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
        checks++; if (alu_stall_o !== 1'b0 || lsu_ready_o !== 1'b1) begin failures++; $display("FAIL x0_handshake: got stall=%0b ready=%0b expected 0/1", alu_stall_o, lsu_ready_o); end
        tick();
        checks++; if (rd_wr_o !== 1'b0 || count_o !== 3'd0) begin failures++; $display("FAIL x0_discard: got wr=%0b count=%0d expected 0/0", rd_wr_o, count_o); end
    endtask

    task automatic test_reset_mid();
        for (int i = 1; i <= 3; i++) begin
            model_step(1'b1, 5'(21 + i), $urandom, 1'b1, 5'(i), $urandom);
            tick();
        end
        alu_wr_i = 1'b0; lsu_valid_i = 1'b0;
        #1;
        checks++; if (count_o !== 3'd3) begin failures++; $display("FAIL rstmid_pre_count: got %0d expected 3", count_o); end
        #1 rst_i = 1'b1;
        #1;
        checks++; if (rd_wr_o !== 1'b0 || count_o !== 3'd0 || lsu_ready_o !== 1'b0)
            begin failures++; $display("FAIL rstmid_immediate: got wr=%0b count=%0d ready=%0b expected 0/0/0", rd_wr_o, count_o, lsu_ready_o); end
        q.delete(); cur_wr = 0; cur_addr = 0; cur_data = 0;
        @(posedge clk_i); #3 rst_i = 1'b0;
        @(posedge clk_i); #1;
        model_step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        checks++; if (lsu_ready_o !== 1'b1 || count_o !== 3'd0) begin failures++; $display("FAIL rstmid_release: got ready=%0b count=%0d expected 1/0", lsu_ready_o, count_o); end
        tick();
        checks++; if (rd_wr_o !== 1'b0) begin failures++; $display("FAIL rstmid_stale_write: got wr=%0b expected 0", rd_wr_o); end
    endtask

    task automatic test_bypass();
        model_step(1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 32'h0);
        tick();
        rs1_addr_i = 5'd9; rs2_addr_i = 5'd0;
        model_step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        checks++; if (rs1_fwd_o !== exp_f1 || rs1_fwd_data_o !== exp_fd1)
            begin failures++; $display("FAIL bypass_rs1: got %0b/%0h expected %0b/%0h", rs1_fwd_o, rs1_fwd_data_o, exp_f1, exp_fd1); end
        checks++; if (rs2_fwd_o !== 1'b0 || rs2_fwd_data_o !== 32'h0)
            begin failures++; $display("FAIL bypass_rs2_x0: got %0b/%0h expected 0/0", rs2_fwd_o, rs2_fwd_data_o); end
        tick();
    endtask

    task automatic test_random(input int cycles);
        logic aw; logic [4:0] aa; logic [31:0] ad;
        aw = 0; aa = 0; ad = 0;
        for (int c = 0; c < cycles; c++) begin
            if (!(aw && exp_stall)) begin
                aw = ($urandom_range(0, 99) < 55);
                aa = 5'($urandom_range(0, 7));
                ad = $urandom;
            end
            rs1_addr_i = 5'($urandom_range(0, 7));
            rs2_addr_i = 5'($urandom_range(0, 7));
            model_step(aw, aa, ad, ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom);
            checks++; if (alu_stall_o !== exp_stall) begin failures++; $display("FAIL rand_stall c=%0d: got %0b expected %0b", c, alu_stall_o, exp_stall); end
            checks++; if (lsu_ready_o !== exp_ready) begin failures++; $display("FAIL rand_ready c=%0d: got %0b expected %0b", c, lsu_ready_o, exp_ready); end
            checks++; if (int'(count_o) != exp_count) begin failures++; $display("FAIL rand_count c=%0d: got %0d expected %0d", c, count_o, exp_count); end
            checks++; if ({rs1_fwd_o, rs1_fwd_data_o, rs2_fwd_o, rs2_fwd_data_o} !== {exp_f1, exp_fd1, exp_f2, exp_fd2})
                begin failures++; $display("FAIL rand_fwd c=%0d: got %0b/%0h %0b/%0h expected %0b/%0h %0b/%0h", c, rs1_fwd_o, rs1_fwd_data_o, rs2_fwd_o, rs2_fwd_data_o, exp_f1, exp_fd1, exp_f2, exp_fd2); end
            tick();
            checks++; if (rd_wr_o !== cur_wr || (cur_wr && (rd_addr_o !== cur_addr || rd_data_o !== cur_data)))
                begin failures++; $display("FAIL rand_rd c=%0d: got wr=%0b a=%0d d=%0h expected wr=%0b a=%0d d=%0h", c, rd_wr_o, rd_addr_o, rd_data_o, cur_wr, cur_addr, cur_data); end
        end
    endtask

    initial begin
        test_reset();
        test_alu_single();
        test_fill_and_drain();
        test_waw();
        test_x0();
        test_bypass();
        test_reset_mid();
        test_random(800);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
